imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch stage over a valid/ready request/response interface. It holds a word-addressed program RAM mapped at `BASE_ADDR`, returns one 32-bit instruction per accepted fetch address after a fixed pipeline latency, and buffers responses so fetch may stall without losing data. A separate load port lets the testbench or boot loader write program words.

## Interface
Parameters:
- `BASE_ADDR`, 32'h80000000, byte address of RAM word 0; equals the fetch reset PC.
- `DEPTH_WORDS`, 1024, RAM size in 32-bit words; power of two, at least 2.
- `LATENCY`, 2, cycles from request acceptance to earliest response; at least 1.
- `RESP_FIFO_DEPTH`, 4, response buffer entries; at least `LATENCY`+1.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock
- `rstn_i`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  fetch presents an address
- `req_ready_o`  out  1  responder can accept a request this cycle
- `req_addr_i`  in  32  byte address (PC)
- `resp_valid_o`  out  1  response available
- `resp_ready_i`  in  1  fetch consumes the response
- `resp_pc_o`  out  32  address of the request this response answers
- `resp_instr_o`  out  32  instruction word
- `resp_err_o`  out  1  request was misaligned or out of range
- `load_we_i`  in  1  program-load write strobe
- `load_addr_i`  in  $clog2(DEPTH_WORDS)  word index
- `load_data_i`  in  32  word to write

## Operation
- A request is accepted when `req_valid_i & req_ready_o` is high at a rising edge. A response handshake occurs when `resp_valid_o & resp_ready_i` is high.
- Outstanding counter `cnt` ranges from 0 to `RESP_FIFO_DEPTH`. It increments on accept and decrements on response handshake. If both occur in the same cycle, it is unchanged.
- `req_ready_o = (cnt < RESP_FIFO_DEPTH)`. The signal is combinational from registered state only; it never depends on `req_valid_i`. This credit scheme guarantees the FIFO never overflows, so no pipeline stall logic is needed.
- Address check on accept:
  - `err = (addr[1:0] != 0) | (addr < BASE_ADDR) | (addr - BASE_ADDR >= DEPTH_WORDS*4)`.
  - Word index is `(addr - BASE_ADDR) >> 2`.
- An erroring request still produces exactly one response, with `resp_err_o=1` and `resp_instr_o=32'h00000013` (NOP). The RAM is not read.
- RAM is single read, single write (load port). Reads are read-first: a load to the same word in the accept cycle does not affect that read. The write is visible to requests accepted from the next cycle onward.
- The pipeline is `LATENCY` stages of {valid, pc, instr, err}. Its output is pushed into the response FIFO.
- The FIFO is first-word fall-through. Its head drives `resp_*_o`.
- Responses are returned strictly in request order.
- `resp_*_o` data must hold stable while `resp_valid_o=1` and `resp_ready_i=0`.
- RAM contents are not reset. Only control state and output registers are reset.

## Timing
- Reset values:
  - `req_ready_o`=1 (`cnt`=0).
  - `resp_valid_o`=0.
  - `resp_pc_o`=0, `resp_instr_o`=0, `resp_err_o`=0.
  - Pipeline valids cleared.
  - FIFO pointers and count at 0.
- Latency: a request accepted at edge of cycle N with the FIFO empty gives `resp_valid_o`=1 during cycle N+`LATENCY`.
- Throughput: with `resp_ready_i` held high and `req_valid_i` held high, one request is accepted and one response delivered every cycle, with no bubbles.
- Back-pressure: with `resp_ready_i`=0, `req_ready_o` falls after `RESP_FIFO_DEPTH` accepts. It rises in the cycle after the first response handshake.
- FIFO pointer wrap-around is modulo `RESP_FIFO_DEPTH`. Full and empty are distinguished by an explicit count.
- Asserting reset mid-operation discards all in-flight and buffered responses. After release, `req_ready_o`=1 and no stale response appears.

## Test plan
- Load words 0..3 with 32'h00000093, 32'h00100113, 32'h00200193, 32'h00300213. Request 0x80000000..0x8000000C back-to-back with `resp_ready_i`=1. Required: four responses in cycles N+2..N+5, with matching pc/instr, `err`=0, one per cycle.
- Hold `resp_ready_i`=0 and stream requests. Required: exactly 4 accepts, then `req_ready_o`=0. Raise `resp_ready_i`: responses drain in order, and `req_ready_o` returns to 1 one cycle after the first drain.
- Request 0x80000002 and 0x7FFFFFFC, then `BASE_ADDR`+4096. Required: three responses with `err`=1, `instr`=32'h00000013, and the pc echoed.
- In the same cycle, load word 5 with 32'hDEADBEEF and request 0x80000014. Required: the old data is returned. A next-cycle request returns 32'hDEADBEEF.
- With 3 responses outstanding, pulse `rstn_i` low. Required: `resp_valid_o`=0 immediately, `req_ready_o`=1, and no response appears after release until a new request is made.
- Randomly toggle `req_valid_i` and `resp_ready_i` over 1000 cycles against a scoreboard. Required: in-order, lossless responses; `cnt` never exceeds 4; held data is stable.

Source files
------------

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch stage. Holds a word-addressed
// program RAM mapped at BASE_ADDR, returns one 32-bit instruction per accepted
// fetch address after LATENCY cycles, and buffers responses in a
// first-word-fall-through FIFO so fetch may stall without losing data.
// A separate load port writes program words.
//
// Ports:
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   req_valid_i   fetch presents an address
//   req_ready_o   responder can accept a request this cycle
//   req_addr_i    byte address (PC)
//   resp_valid_o  response available
//   resp_ready_i  fetch consumes the response
//   resp_pc_o     address of the request this response answers
//   resp_instr_o  instruction word (NOP on error)
//   resp_err_o    request was misaligned or out of range
//   load_we_i     program-load write strobe
//   load_addr_i   program-load word index
//   load_data_i   program-load word
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h80000000,
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned RESP_FIFO_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [31:0]                    req_addr_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [31:0]                    resp_pc_o,
    output logic [31:0]                    resp_instr_o,
    output logic                           resp_err_o,
    input  logic                           load_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                    load_data_i
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(RESP_FIFO_DEPTH);
    localparam int unsigned CW = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int unsigned LT = LATENCY - 1;
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH_WORDS];

    // Pipeline stages {valid, pc, instr, err}; stage 0 holds the RAM read.
    logic        r_p_valid [LATENCY];
    logic [31:0] r_p_pc    [LATENCY];
    logic [31:0] r_p_instr [LATENCY];
    logic        r_p_err   [LATENCY];

    // Response FIFO
    logic [31:0] r_f_pc    [RESP_FIFO_DEPTH];
    logic [31:0] r_f_instr [RESP_FIFO_DEPTH];
    logic        r_f_err   [RESP_FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_f_cnt;

    // Outstanding-request credit counter
    logic [CW-1:0] r_cnt;

    // ---------------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------------
    logic          w_accept;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic          w_f_empty;
    logic [32:0]   w_off;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // Offset is computed one bit wider so addr < BASE_ADDR shows up as bit 32.
    always_comb begin
        w_off = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
        w_err = (req_addr_i[1:0] != 2'b00) | w_off[32] | (w_off >= RAM_BYTES);
        w_idx = w_off[AW+1:2];
    end

    always_comb begin
        req_ready_o = (r_cnt < CW'(RESP_FIFO_DEPTH));
        w_accept    = req_valid_i & req_ready_o;
        w_f_empty   = (r_f_cnt == '0);

        // When the FIFO is empty the last pipeline stage is presented directly,
        // so the response is visible without an extra FIFO cycle. If it is not
        // consumed it is pushed, and the FIFO head then shows the same data.
        resp_valid_o = ~w_f_empty | r_p_valid[LT];
        if (w_f_empty) begin
            resp_pc_o    = r_p_pc[LT];
            resp_instr_o = r_p_instr[LT];
            resp_err_o   = r_p_err[LT];
        end else begin
            resp_pc_o    = r_f_pc[r_rd_ptr];
            resp_instr_o = r_f_instr[r_rd_ptr];
            resp_err_o   = r_f_err[r_rd_ptr];
        end

        w_hs   = resp_valid_o & resp_ready_i;
        w_pop  = ~w_f_empty & resp_ready_i;
        w_push = r_p_valid[LT] & ~(w_f_empty & resp_ready_i);
    end

    // ---------------------------------------------------------------------
    // Program RAM write port (contents are not reset)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            r_mem[load_addr_i] <= load_data_i;
        end
    end

    // ---------------------------------------------------------------------
    // Credit counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (w_accept && !w_hs) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (!w_accept && w_hs) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Fetch pipeline; the RAM read is read-first against the load port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_p_valid[i] <= 1'b0;
                r_p_pc[i]    <= '0;
                r_p_instr[i] <= '0;
                r_p_err[i]   <= 1'b0;
            end
        end else begin
            r_p_valid[0] <= w_accept;
            if (w_accept) begin
                r_p_pc[0]    <= req_addr_i;
                r_p_err[0]   <= w_err;
                r_p_instr[0] <= w_err ? NOP : r_mem[w_idx];
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_p_valid[i] <= r_p_valid[i-1];
                r_p_pc[i]    <= r_p_pc[i-1];
                r_p_instr[i] <= r_p_instr[i-1];
                r_p_err[i]   <= r_p_err[i-1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response FIFO: storage unreset, pointers and count reset
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_f_pc[r_wr_ptr]    <= r_p_pc[LT];
            r_f_instr[r_wr_ptr] <= r_p_instr[LT];
            r_f_err[r_wr_ptr]   <= r_p_err[LT];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_f_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_f_cnt <= r_f_cnt + CW'(1);
            end else if (!w_push && w_pop) begin
                r_f_cnt <= r_f_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Self-checking bench for imem_responder. A transaction-level model keeps a
// queue of expected responses, each tagged with the earliest cycle it may
// appear, plus a shadow copy of the program RAM and an outstanding count.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h80000000;
    localparam int          WORDS = 1024;
    localparam int          LAT   = 2;
    localparam int          FDEP  = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_pc_o;
    logic [31:0] resp_instr_o;
    logic        resp_err_o;
    logic        load_we_i;
    logic [9:0]  load_addr_i;
    logic [31:0] load_data_i;

    imem_responder #(
        .BASE_ADDR      (BASE),
        .DEPTH_WORDS    (WORDS),
        .LATENCY        (LAT),
        .RESP_FIFO_DEPTH(FDEP)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_pc_o   (resp_pc_o),
        .resp_instr_o(resp_instr_o),
        .resp_err_o  (resp_err_o),
        .load_we_i   (load_we_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          avail;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mmem [WORDS];
    int          mcnt = 0;
    int          now  = 0;
    int          n_assert = 0;
    int          n_fail   = 0;

    // Drives one cycle of stimulus (called at a negedge), advances the model,
    // and returns at the next negedge.
    task automatic tick(input logic rv, input logic [31:0] addr, input logic rr,
                        input logic we, input logic [9:0] la, input logic [31:0] ld,
                        output bit acc);
        exp_t e;
        bit   hs;
        req_valid_i  = rv;
        req_addr_i   = addr;
        resp_ready_i = rr;
        load_we_i    = we;
        load_addr_i  = la;
        load_data_i  = ld;
        acc = rv && (mcnt < FDEP);
        hs  = rr && (q.size() > 0) && (q[0].avail <= now);
        if (hs) void'(q.pop_front());
        if (acc) begin
            e.pc    = addr;
            e.err   = (addr[1:0] != 2'b00) || (addr < BASE) ||
                      (longint'(addr) - longint'(BASE) >= longint'(WORDS * 4));
            e.instr = e.err ? NOP : mmem[(addr - BASE) >> 2];
            e.avail = now + LAT;
            q.push_back(e);
        end
        mcnt = mcnt + int'(acc) - int'(hs);
        if (we) mmem[la] = ld;
        @(posedge clk_i);
        now++;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        n_assert++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        n_assert++;
        if (resp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", resp_valid_o);
        end
        n_assert++;
        if ({resp_pc_o, resp_instr_o, resp_err_o} !== 65'd0) begin
            n_fail++; $display("FAIL reset_data: got pc=%h instr=%h err=%b want zeros",
                               resp_pc_o, resp_instr_o, resp_err_o);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n0, seen;
        logic [31:0] prog [4];
        prog[0] = 32'h00000093; prog[1] = 32'h00100113;
        prog[2] = 32'h00200193; prog[3] = 32'h00300213;
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 1, 10'(i), prog[i], acc);
        n0 = now;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid_o === 1'b1) begin
                n_assert++;
                if (seen >= 4 || now !== n0 + LAT + seen) begin
                    n_fail++; $display("FAIL b2b_timing: response %0d at cycle %0d want %0d",
                                       seen, now - n0, LAT + seen);
                end else begin
                    n_assert++;
                    if (resp_pc_o !== BASE + 32'(4 * seen) || resp_instr_o !== prog[seen] ||
                        resp_err_o !== 1'b0) begin
                        n_fail++; $display("FAIL b2b_data: got pc=%h instr=%h err=%b want pc=%h instr=%h err=0",
                                           resp_pc_o, resp_instr_o, resp_err_o,
                                           BASE + 32'(4 * seen), prog[seen]);
                    end
                end
                seen++;
            end
            if (c < 4) tick(1, BASE + 32'(4 * c), 1, 0, 0, 0, acc);
            else       tick(0, 0, 1, 0, 0, 0, acc);
        end
        n_assert++;
        if (seen !== 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d responses want 4", seen);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int nacc = 0;
        bit exp_v;
        for (int c = 0; c < 7; c++) begin
            n_assert++;
            if (req_ready_o !== (mcnt < FDEP)) begin
                n_fail++; $display("FAIL bp_ready: got %b want %b cycle %0d", req_ready_o, mcnt < FDEP, c);
            end
            tick(1, BASE + 32'(4 * c), 0, 0, 0, 0, acc);
            nacc += int'(acc);
        end
        n_assert++;
        if (nacc !== FDEP || req_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_accepts: got %0d accepts ready=%b want %0d ready=0",
                               nacc, req_ready_o, FDEP);
        end
        // Drain; ready must come back exactly one cycle after the first handshake.
        for (int c = 0; c < 8; c++) begin
            exp_v = (q.size() > 0) && (q[0].avail <= now);
            n_assert++;
            if (resp_valid_o !== exp_v) begin
                n_fail++; $display("FAIL bp_valid: got %b want %b", resp_valid_o, exp_v);
            end
            if (exp_v) begin
                n_assert++;
                if (resp_pc_o !== q[0].pc || resp_instr_o !== q[0].instr || resp_err_o !== q[0].err) begin
                    n_fail++; $display("FAIL bp_data: got pc=%h instr=%h want pc=%h instr=%h",
                                       resp_pc_o, resp_instr_o, q[0].pc, q[0].instr);
                end
            end
            n_assert++;
            if (req_ready_o !== (c >= 1)) begin
                n_fail++; $display("FAIL bp_reready: got %b want %b drain cycle %0d", req_ready_o, c >= 1, c);
            end
            tick(0, 0, 1, 0, 0, 0, acc);
        end
    endtask

    task automatic test_errors();
        bit acc;
        int seen = 0;
        logic [31:0] bad [3];
        bad[0] = 32'h80000002; bad[1] = 32'h7FFFFFFC; bad[2] = BASE + 32'd4096;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid_o === 1'b1) begin
                n_assert++;
                if (seen >= 3 || resp_pc_o !== bad[seen] || resp_instr_o !== NOP || resp_err_o !== 1'b1) begin
                    n_fail++; $display("FAIL err_resp: #%0d got pc=%h instr=%h err=%b", seen,
                                       resp_pc_o, resp_instr_o, resp_err_o);
                end
                seen++;
            end
            if (c < 3) tick(1, bad[c], 1, 0, 0, 0, acc);
            else       tick(0, 0, 1, 0, 0, 0, acc);
        end
        n_assert++;
        if (seen !== 3) begin
            n_fail++; $display("FAIL err_count: got %0d want 3", seen);
        end
    endtask

    task automatic test_read_first();
        bit acc;
        int seen = 0;
        logic [31:0] want [2];
        want[0] = 32'h12345678; want[1] = 32'hDEADBEEF;
        tick(0, 0, 1, 1, 10'd5, 32'h12345678, acc);
        tick(1, 32'h80000014, 1, 1, 10'd5, 32'hDEADBEEF, acc);
        tick(1, 32'h80000014, 1, 0, 0, 0, acc);
        for (int c = 0; c < 5; c++) begin
            if (resp_valid_o === 1'b1) begin
                n_assert++;
                if (seen >= 2 || resp_instr_o !== want[seen] || resp_err_o !== 1'b0) begin
                    n_fail++; $display("FAIL read_first: #%0d got instr=%h err=%b", seen,
                                       resp_instr_o, resp_err_o);
                end
                seen++;
            end
            tick(0, 0, 1, 0, 0, 0, acc);
        end
        n_assert++;
        if (seen !== 2) begin
            n_fail++; $display("FAIL read_first_count: got %0d want 2", seen);
        end
    endtask

    task automatic test_reset_midflight();
        bit acc;
        for (int c = 0; c < 3; c++) tick(1, BASE + 32'(4 * c), 0, 0, 0, 0, acc);
        #2 rstn_i = 1'b0;
        #1;
        n_assert++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset: got valid=%b ready=%b want valid=0 ready=1",
                               resp_valid_o, req_ready_o);
        end
        q.delete();
        mcnt = 0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            n_assert++;
            if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL post_reset_stale: got valid=%b ready=%b cycle %0d",
                                   resp_valid_o, req_ready_o, c);
            end
            tick(0, 0, 1, 0, 0, 0, acc);
        end
    endtask

    task automatic test_random();
        bit acc;
        bit exp_v;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) tick(0, 0, 1, 1, 10'(i), $urandom, acc);
        for (int c = 0; c < 1000; c++) begin
            exp_v = (q.size() > 0) && (q[0].avail <= now);
            n_assert++;
            if (resp_valid_o !== exp_v || req_ready_o !== (mcnt < FDEP)) begin
                n_fail++; $display("FAIL rand_ctrl: cycle %0d got valid=%b ready=%b want valid=%b ready=%b",
                                   c, resp_valid_o, req_ready_o, exp_v, mcnt < FDEP);
            end
            if (exp_v) begin
                n_assert++;
                if (resp_pc_o !== q[0].pc || resp_instr_o !== q[0].instr || resp_err_o !== q[0].err) begin
                    n_fail++; $display("FAIL rand_data: cycle %0d got pc=%h instr=%h err=%b want pc=%h instr=%h err=%b",
                                       c, resp_pc_o, resp_instr_o, resp_err_o,
                                       q[0].pc, q[0].instr, q[0].err);
                end
            end
            if ($urandom_range(0, 9) == 0) a = BASE + 32'($urandom_range(0, 255));
            else                           a = BASE + 32'(4 * $urandom_range(0, 63));
            tick(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) == 0), 10'($urandom_range(0, 63)), $urandom, acc);
        end
    endtask

    initial begin
        rstn_i       = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        resp_ready_i = 1'b0;
        load_we_i    = 1'b0;
        load_addr_i  = '0;
        load_data_i  = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        test_reset();
        rstn_i = 1'b1;
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_read_first();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
